alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_alu_issue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: instruction buffer + decode/issue stage for a small ALU.
// Raw 25-bit instruction words are queued in a FIFO and decoded only when
// they leave it. The decoded operation is held in a registered output slot
// with a valid/ready handshake toward the execute stage.
//
// Optional feature: define ALU_ISSUE_ILLEGAL_TRAP_EN to drop R3 words whose
// opcode is not a known R3 operation (or NOP). A dropped word is never
// presented, and err pulses for one cycle. When the macro is undefined,
// every R3 opcode is passed through and err stays 0.
//
// Opcode macros are supplied here unless the including build already
// defines them.

`ifndef op_ADD
`define op_ADD       8'h01
`endif
`ifndef op_SUB
`define op_SUB       8'h02
`endif
`ifndef op_AND
`define op_AND       8'h03
`endif
`ifndef op_OR
`define op_OR        8'h04
`endif
`ifndef op_XOR
`define op_XOR       8'h05
`endif
`ifndef op_NOT
`define op_NOT       8'h06
`endif
`ifndef op_SLL
`define op_SLL       8'h07
`endif
`ifndef op_SRL
`define op_SRL       8'h08
`endif
`ifndef op_SRA
`define op_SRA       8'h09
`endif
`ifndef op_MUL
`define op_MUL       8'h0A
`endif
`ifndef op_MIN
`define op_MIN       8'h0B
`endif
`ifndef op_MAX
`define op_MAX       8'h0C
`endif
`ifndef op_CLZ
`define op_CLZ       8'h0D
`endif
`ifndef op_POPCNT
`define op_POPCNT    8'h0E
`endif
`ifndef op_ROT
`define op_ROT       8'h0F
`endif
`ifndef op_LI
`define op_LI        8'h11
`endif
`ifndef op_group_R4I
`define op_group_R4I 8'h12
`endif
`ifndef op_group_R4L
`define op_group_R4L 8'h13
`endif

module alu_issue #(
   parameter int INSTR_WIDTH = 25,
   parameter int CTRL_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_WIDTH-1:0]  out_ctrl,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [4:0]             out_rs3,
   output logic [4:0]             out_rd,
   output logic [15:0]            out_imm,
   output logic                   out_we,
   output logic                   err
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1'b1);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   // Opcode constants held in typed parameters so their low bits can be sliced.
   localparam logic [7:0] OP_LI     = `op_LI;
   localparam logic [7:0] OP_GRP_R4I = `op_group_R4I;
   localparam logic [7:0] OP_GRP_R4L = `op_group_R4L;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   typedef struct packed {
      logic [CTRL_WIDTH-1:0] ctrl;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rs3;
      logic [4:0]            rd;
      logic [15:0]           imm;
      logic                  we;
      logic                  illegal;
   } dec_t;

   // Field extraction for the three instruction formats. 'illegal' flags
   // an R3 opcode outside the known set; whether it matters is decided by
   // the trap configuration.
   function automatic dec_t decode_instr(input logic [INSTR_WIDTH-1:0] w);
      dec_t d;
      d = '0;
      if (w[24] == 1'b0) begin
         // LI: immediate load, rs1 doubles as the destination
         d.ctrl = CTRL_WIDTH'({w[23:21], OP_LI[4:0]});
         d.imm  = w[20:5];
         d.rs1  = w[4:0];
         d.rd   = w[4:0];
         d.we   = 1'b1;
      end else if (w[23] == 1'b0) begin
         // R4: four-register form, group selected by bit 22
         d.ctrl = CTRL_WIDTH'({1'b0, w[21:20],
                               (w[22] ? OP_GRP_R4L[4:0] : OP_GRP_R4I[4:0])});
         d.rs3  = w[19:15];
         d.rs2  = w[14:10];
         d.rs1  = w[9:5];
         d.rd   = w[4:0];
         d.we   = 1'b1;
      end else begin
         // R3: opcode carried verbatim; all-zero opcode is a NOP with no write
         d.ctrl = CTRL_WIDTH'(w[22:15]);
         d.rs2  = w[14:10];
         d.rs1  = w[9:5];
         d.rd   = w[4:0];
         case (w[22:15])
            8'h00: begin
               d.we      = 1'b0;
               d.illegal = 1'b0;
            end
            `op_ADD, `op_SUB, `op_AND, `op_OR, `op_XOR,
            `op_NOT, `op_SLL, `op_SRL, `op_SRA, `op_MUL,
            `op_MIN, `op_MAX, `op_CLZ, `op_POPCNT, `op_ROT: begin
               d.we      = 1'b1;
               d.illegal = 1'b0;
            end
            default: begin
               d.we      = 1'b1;
               d.illegal = 1'b1;
            end
         endcase
      end
      return d;
   endfunction

   // Buffer storage and bookkeeping
   logic [INSTR_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r;
   logic [PTR_W-1:0]       rd_ptr_r;
   logic [PTR_W:0]         count_r;
   logic [PTR_W:0]         count_nxt_s;
   logic                   in_ready_r;

   // Output slot
   logic                   out_valid_r;
   logic [CTRL_WIDTH-1:0]  out_ctrl_r;
   logic [4:0]             out_rs1_r;
   logic [4:0]             out_rs2_r;
   logic [4:0]             out_rs3_r;
   logic [4:0]             out_rd_r;
   logic [15:0]            out_imm_r;
   logic                   out_we_r;
   logic                   err_r;

   logic                   push_s;
   logic                   pop_s;
   logic                   drop_s;
   logic [INSTR_WIDTH-1:0] head_word_s;
   dec_t                   head_dec_s;

   assign push_s = in_valid && in_ready_r;
   // The head leaves the buffer whenever the output slot is free or being vacated.
   assign pop_s  = (count_r != '0) && (!out_valid_r || out_ready);
   assign drop_s = TRAP_EN && head_dec_s.illegal;

   // Decode the buffer head so it is ready to load into the output slot.
   always_comb begin
      head_word_s = mem_r[rd_ptr_r];
      head_dec_s  = decode_instr(head_word_s);
   end

   // Next occupancy from the push/pop combination; simultaneous push and pop cancel.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Raw word storage; contents beyond the occupancy are never read, so no reset.
   always_ff @(posedge clk) begin
      if (rst_n && push_s) begin
         mem_r[wr_ptr_r] <= in_instr;
      end
   end

   // Pointers, occupancy and the registered ready flag (depends only on state).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         in_ready_r <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r    <= count_nxt_s;
         in_ready_r <= (count_nxt_s < DEPTH_C);
      end
   end

   // Output slot: load the decoded head, hold under backpressure, clear after hand-off.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_ctrl_r  <= '0;
         out_rs1_r   <= 5'd0;
         out_rs2_r   <= 5'd0;
         out_rs3_r   <= 5'd0;
         out_rd_r    <= 5'd0;
         out_imm_r   <= 16'd0;
         out_we_r    <= 1'b0;
      end else if (pop_s && !drop_s) begin
         out_valid_r <= 1'b1;
         out_ctrl_r  <= head_dec_s.ctrl;
         out_rs1_r   <= head_dec_s.rs1;
         out_rs2_r   <= head_dec_s.rs2;
         out_rs3_r   <= head_dec_s.rs3;
         out_rd_r    <= head_dec_s.rd;
         out_imm_r   <= head_dec_s.imm;
         out_we_r    <= head_dec_s.we;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // One-cycle pulse when an illegal R3 word is popped and discarded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else begin
         err_r <= pop_s && drop_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_ctrl  = out_ctrl_r;
   assign out_rs1   = out_rs1_r;
   assign out_rs2   = out_rs2_r;
   assign out_rs3   = out_rs3_r;
   assign out_rd    = out_rd_r;
   assign out_imm   = out_imm_r;
   assign out_we    = out_we_r;
   assign err       = err_r;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed instruction words, expected decoded ops
// queued at acceptance and compared by an independent output monitor.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [24:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_ctrl;
   logic [4:0]  out_rs1, out_rs2, out_rs3, out_rd;
   logic [15:0] out_imm;
   logic        out_we;
   logic        err;

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rs3;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic        we;
   } exp_t;

   exp_t exp_q[$];
   int   total    = 0;
   int   bad      = 0;
   int   err_seen = 0;
   int   err_exp  = 0;

   alu_issue #(.INSTR_WIDTH(25), .CTRL_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rs3(out_rs3), .out_rd(out_rd), .out_imm(out_imm),
      .out_we(out_we), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] c, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] r3, input logic [4:0] d,
                               input logic [15:0] im, input logic w);
      exp_t e;
      e.ctrl = c; e.rs1 = r1; e.rs2 = r2; e.rs3 = r3; e.rd = d; e.imm = im; e.we = w;
      return e;
   endfunction

   // Monitor: every handshake on the output side is checked against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (err === 1'b1) err_seen++;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_op: actual ctrl=%0h rd=%0h required=no op", out_ctrl, out_rd);
            end else begin
               e = exp_q.pop_front();
               check("mon_ctrl", {24'd0, out_ctrl}, {24'd0, e.ctrl});
               check("mon_rs1",  {27'd0, out_rs1},  {27'd0, e.rs1});
               check("mon_rs2",  {27'd0, out_rs2},  {27'd0, e.rs2});
               check("mon_rs3",  {27'd0, out_rs3},  {27'd0, e.rs3});
               check("mon_rd",   {27'd0, out_rd},   {27'd0, e.rd});
               check("mon_imm",  {16'd0, out_imm},  {16'd0, e.imm});
               check("mon_we",   {31'd0, out_we},   {31'd0, e.we});
            end
         end
      end
   end

   // Present one word until accepted; queue its expectation at the accepting edge.
   task automatic send(input logic [24:0] w, input exp_t e, input bit expect_out);
      int n = 0;
      in_valid = 1'b1;
      in_instr = w;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL send_timeout: actual in_ready=%0b required=1", in_ready);
         in_valid = 1'b0;
      end else begin
         if (expect_out) exp_q.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cycles;
      logic [24:0] w;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 25'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_ctrl",  {24'd0, out_ctrl},  32'd0);
      check("rst_idx",       {12'd0, out_rs1, out_rs2, out_rs3, out_rd}, 32'd0);
      check("rst_out_imm",   {16'd0, out_imm},   32'd0);
      check("rst_out_we",    {31'd0, out_we},    32'd0);
      check("rst_err",       {31'd0, err},       32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);

      // LI with latency check
      out_ready = 1'b1;
      send({1'b0, 3'd5, 16'hBEEF, 5'd7}, mk(8'hB1, 5'd7, 5'd0, 5'd0, 5'd7, 16'hBEEF, 1'b1), 1'b1);
      check("li_not_yet_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("li_valid",   {31'd0, out_valid}, 32'd1);
      check("li_ctrl_hi", {29'd0, out_ctrl[7:5]}, 32'd5);
      check("li_imm",     {16'd0, out_imm}, 32'h0000BEEF);
      check("li_rd",      {27'd0, out_rd}, 32'd7);
      check("li_we",      {31'd0, out_we}, 32'd1);

      // R4 (both groups), R3 NOP and R3 AND, streamed back to back
      send({2'b10, 3'b110, 5'd3, 5'd2, 5'd1, 5'd9}, mk(8'h53, 5'd1, 5'd2, 5'd3, 5'd9, 16'd0, 1'b1), 1'b1);
      send({2'b10, 3'b001, 5'd4, 5'd5, 5'd6, 5'd7}, mk(8'h32, 5'd6, 5'd5, 5'd4, 5'd7, 16'd0, 1'b1), 1'b1);
      send({2'b11, 8'h00, 5'd4, 5'd5, 5'd6},        mk(8'h00, 5'd5, 5'd4, 5'd0, 5'd6, 16'd0, 1'b0), 1'b1);
      send({2'b11, 8'h03, 5'd10, 5'd11, 5'd12},     mk(8'h03, 5'd11, 5'd10, 5'd0, 5'd12, 16'd0, 1'b1), 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("drain1_empty", exp_q.size(), 32'd0);

      // Backpressure: five accepted, buffer full, extra word held off
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send({1'b0, 3'd1, 16'h1000 + 16'(i), 5'(i)},
              mk(8'h31, 5'(i), 5'd0, 5'd0, 5'(i), 16'h1000 + 16'(i), 1'b1), 1'b1);
      end
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      in_instr = {1'b0, 3'd2, 16'h2222, 5'd22};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("full_hold", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
      check("drain_cycles", cycles, 32'd5);
      check("drain_idle", {31'd0, out_valid}, 32'd0);

      // Reset with a full buffer: everything discarded
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send({1'b0, 3'd3, 16'h3000 + 16'(i), 5'(i + 8)},
              mk(8'h71, 5'(i + 8), 5'd0, 5'd0, 5'(i + 8), 16'h3000 + 16'(i), 1'b1), 1'b1);
      end
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_in_ready",  {31'd0, in_ready},  32'd1);
      check("mrst_out_ctrl",  {24'd0, out_ctrl},  32'd0);
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("mrst_no_stale", {31'd0, out_valid}, 32'd0);

      // Illegal R3 opcode between two legal ops
      send({2'b11, 8'h03, 5'd1, 5'd2, 5'd3}, mk(8'h03, 5'd2, 5'd1, 5'd0, 5'd3, 16'd0, 1'b1), 1'b1);
      w = {2'b11, 8'hFF, 5'd4, 5'd5, 5'd6};
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      send(w, mk(8'hFF, 5'd5, 5'd4, 5'd0, 5'd6, 16'd0, 1'b1), 1'b0);
      err_exp = 1;
`else
      send(w, mk(8'hFF, 5'd5, 5'd4, 5'd0, 5'd6, 16'd0, 1'b1), 1'b1);
      err_exp = 0;
`endif
      send({1'b0, 3'd0, 16'h0001, 5'd31}, mk(8'h11, 5'd31, 5'd0, 5'd0, 5'd31, 16'h0001, 1'b1), 1'b1);
      repeat (6) @(posedge clk);
      #1;
      check("final_empty", exp_q.size(), 32'd0);
      check("err_pulses",  err_seen, err_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
